// File: rtl/adder_pipe.sv
// Carry-pipelined N-bit add/subtract unit with valid/ready handshake.
// Each stage resolves one W-bit chunk; the upper operand chunks ride along in skew registers.
module adder_pipe #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);
    localparam int W = N / STAGES;

    if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad
        $error("adder_pipe: STAGES must divide N and lie in 1..N");
    end

    logic         stall;
    logic [N-1:0] bx;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign bx       = B ^ {N{mode}};

    for (genvar k = 0; k < STAGES; k++) begin : g
        localparam int LO = k * W;
        localparam int R  = N - LO;

        logic [R-1:0]    ai;
        logic [R-1:0]    bi;
        logic            ci;
        logic            vi;
        logic [W:0]      t;
        logic [LO+W-1:0] s_d;
        logic [LO+W-1:0] s_q;
        logic            c_q;
        logic            v_q;

        if (k == 0) begin : g_in
            assign ai  = A;
            assign bi  = bx;
            assign ci  = mode;
            assign vi  = in_valid;
            assign s_d = t[W-1:0];
        end else begin : g_in
            assign ai  = g[k-1].g_sk.a_q;
            assign bi  = g[k-1].g_sk.b_q;
            assign ci  = g[k-1].c_q;
            assign vi  = g[k-1].v_q;
            assign s_d = {t[W-1:0], g[k-1].s_q};
        end

        assign t = {1'b0, ai[W-1:0]} + {1'b0, bi[W-1:0]} + {{W{1'b0}}, ci};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (!stall) begin
                s_q <= s_d;
                c_q <= t[W];
                v_q <= vi;
            end
        end

        if (k < STAGES - 1) begin : g_sk
            logic [R-W-1:0] a_q;
            logic [R-W-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    a_q <= ai[R-1:W];
                    b_q <= bi[R-1:W];
                end
            end
        end else begin : g_out
            logic cmsb;
            logic ovf_q;
            logic zero_q;

            // carry into the MSB falls out of the MSB sum bit
            assign cmsb = t[W-1] ^ ai[W-1] ^ bi[W-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (!stall) begin
                    ovf_q  <= cmsb ^ t[W];
                    zero_q <= (s_d == '0);
                end
            end

            assign S         = s_q;
            assign cout      = c_q;
            assign out_valid = v_q;
            assign ovf       = ovf_q;
            assign zero      = zero_q;
        end
    end
endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: directed cases on (8,2) plus random traffic on a
// parameter sweep, all scored against a slot-delay reference model.
module tb_adder_pipe;
    localparam int ND = 5;
    localparam int CN [ND] = '{8, 8, 8, 32, 64};
    localparam int CS [ND] = '{2, 1, 8, 4, 2};

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        v;
        logic        z;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ival [ND];
    logic        mode [ND];
    logic        ordy [ND];
    logic        irdy [ND];
    logic        oval [ND];
    logic        co   [ND];
    logic        ov   [ND];
    logic        zr   [ND];
    logic [63:0] a    [ND];
    logic [63:0] b    [ND];
    logic [63:0] s    [ND];

    res_t pipe [ND][8];
    logic pv   [ND][8];

    int n_chk  = 0;
    int n_fail = 0;

    for (genvar i = 0; i < ND; i++) begin : g_dut
        localparam int NN = CN[i];
        logic [NN-1:0] so;

        adder_pipe #(.N(NN), .STAGES(CS[i])) u_dut (
            .clk(clk),
            .rst(rst),
            .in_valid(ival[i]),
            .in_ready(irdy[i]),
            .mode(mode[i]),
            .A(a[i][NN-1:0]),
            .B(b[i][NN-1:0]),
            .out_valid(oval[i]),
            .out_ready(ordy[i]),
            .S(so),
            .cout(co[i]),
            .ovf(ov[i]),
            .zero(zr[i])
        );

        assign s[i] = 64'(so);
    end

    function automatic res_t ref_op(int n, logic m, logic [63:0] a0, logic [63:0] b0);
        logic [63:0] mask;
        logic [63:0] x;
        logic [63:0] y;
        logic [64:0] sum;
        res_t        r;
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        x = a0 & mask;
        y = b0 & mask;
        if (m) begin
            r.s = (x - y) & mask;
            r.c = (x >= y);
            r.v = (x[n-1] != y[n-1]) && (r.s[n-1] != x[n-1]);
        end else begin
            sum = {1'b0, x} + {1'b0, y};
            r.s = sum[63:0] & mask;
            r.c = sum[n];
            r.v = (x[n-1] == y[n-1]) && (r.s[n-1] != x[n-1]);
        end
        r.z = (r.s == 64'd0);
        return r;
    endfunction

    task automatic chk(string nm, logic [67:0] got, logic [67:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] pick(int n);
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            2:       v = 64'd1 << (n - 1);
            3:       v = (64'd1 << (n - 1)) - 64'd1;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic drive_rand(int i);
        ival[i] = ($urandom_range(0, 3) != 0);
        mode[i] = 1'($urandom_range(0, 1));
        a[i]    = pick(CN[i]);
        b[i]    = pick(CN[i]);
        ordy[i] = ($urandom_range(0, 3) != 0);
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            int   st;
            logic eov;
            logic stl;
            st = CS[i];
            if (rst) begin
                chk($sformatf("dut%0d reset outs", i),
                    68'({s[i], oval[i], co[i], ov[i], zr[i]}), 68'd0);
                chk($sformatf("dut%0d reset in_ready", i), 68'(irdy[i]), 68'd1);
                for (int k = 0; k < 8; k++) pv[i][k] = 1'b0;
            end else begin
                eov = pv[i][st-1];
                stl = eov && !ordy[i];
                chk($sformatf("dut%0d out_valid", i), 68'(oval[i]), 68'(eov));
                chk($sformatf("dut%0d in_ready", i), 68'(irdy[i]), 68'(!stl));
                if (eov)
                    chk($sformatf("dut%0d result", i),
                        68'({s[i], co[i], ov[i], zr[i]}), 68'(pipe[i][st-1]));
                if (!stl) begin
                    for (int k = st - 1; k > 0; k--) begin
                        pipe[i][k] = pipe[i][k-1];
                        pv[i][k]   = pv[i][k-1];
                    end
                    pv[i][0]   = ival[i];
                    pipe[i][0] = ref_op(CN[i], mode[i], a[i], b[i]);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 1; i < ND; i++) drive_rand(i);
    endtask

    task automatic send(logic m, logic [63:0] x, logic [63:0] y);
        ival[0] = 1'b1;
        mode[0] = m;
        a[0]    = x;
        b[0]    = y;
        tick();
    endtask

    task automatic idle();
        ival[0] = 1'b0;
        tick();
    endtask

    task automatic lit(string nm, logic [63:0] es, logic [2:0] fl);
        chk(nm, {oval[0], s[0], co[0], ov[0], zr[0]}, {1'b1, es, fl});
    endtask

    initial begin
        res_t r;
        int   cnt;
        for (int i = 0; i < ND; i++) begin
            ival[i] = 1'b0;
            mode[i] = 1'b0;
            a[i]    = '0;
            b[i]    = '0;
            ordy[i] = 1'b1;
            for (int k = 0; k < 8; k++) pv[i][k] = 1'b0;
        end

        r = ref_op(8, 1'b0, 64'h7F, 64'h01);
        chk("model 7F+01", 68'(r), {4'd0, 64'h80, 3'b010});
        r = ref_op(8, 1'b1, 64'h05, 64'h07);
        chk("model 05-07", 68'(r), {4'd0, 64'hFE, 3'b000});
        r = ref_op(8, 1'b1, 64'h80, 64'h01);
        chk("model 80-01", 68'(r), {4'd0, 64'h7F, 3'b110});
        r = ref_op(8, 1'b1, 64'h33, 64'h33);
        chk("model 33-33", 68'(r), {4'd0, 64'h00, 3'b101});
        r = ref_op(64, 1'b0, '1, 64'h1);
        chk("model 64b wrap", 68'(r), {4'd0, 64'h0, 3'b101});

        repeat (3) tick();
        rst = 1'b0;
        chk("in_ready after reset", 68'(irdy[0]), 68'd1);

        send(1'b0, 64'h7F, 64'h01);
        idle();
        lit("7F+01 at t+2", 64'h80, 3'b010);
        idle();

        send(1'b1, 64'h05, 64'h07);
        send(1'b1, 64'h80, 64'h01);
        lit("05-07", 64'hFE, 3'b000);
        send(1'b1, 64'h33, 64'h33);
        lit("80-01", 64'h7F, 3'b110);
        idle();
        lit("33-33", 64'h00, 3'b101);
        idle();

        cnt = 0;
        for (int j = 0; j < 8; j++) begin
            send(1'(j % 2), 64'($urandom), 64'($urandom));
            cnt += int'(oval[0]);
        end
        for (int j = 0; j < 4; j++) begin
            idle();
            cnt += int'(oval[0]);
        end
        chk("back-to-back beat count", 68'(cnt), 68'd8);

        for (int j = 0; j < 3; j++) send(1'b0, 64'(j * 17 + 3), 64'(j + 100));
        ordy[0] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            send(1'b1, 64'(j + 7), 64'(j + 9));
            chk("stall in_ready", 68'(irdy[0]), 68'd0);
        end
        ordy[0] = 1'b1;
        repeat (4) idle();

        send(1'b0, 64'h01, 64'h02);
        send(1'b1, 64'h03, 64'h04);
        #2 rst = 1'b1;
        #1 chk("async reset outs", 68'({oval[0], s[0], co[0], ov[0], zr[0]}), 68'd0);
        ival[0] = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        idle();
        idle();
        chk("no stale result", 68'(oval[0]), 68'd0);
        send(1'b0, 64'hFF, 64'h01);
        idle();
        lit("FF+01 after reset", 64'h00, 3'b101);

        for (int j = 0; j < 3000; j++) begin
            drive_rand(0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
